// File: rtl/spike_maxpool2d_unit.sv
// Streaming 2-D spike max-pool, stride 2, with runtime 2x2 (no pad) or 3x3 (pad 1) windows.
// Rows are OR-ed vertically on arrival, then one pooled pixel is produced per cycle.
module spike_maxpool2d_unit #(
  parameter int IMG_WIDTH  = 32,
  parameter int TIME_STEPS = 4,
  parameter int OUT_W      = IMG_WIDTH / 2
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic                           code_valid,
  input  logic [15:0]                    conv_img_size,
  input  logic                           pool_mode,
  input  logic                           i_row_data_valid,
  output logic                           o_row_ready,
  input  logic [IMG_WIDTH*TIME_STEPS-1:0] i_row_data,
  output logic                           o_calculating_flag,
  output logic                           o_pooling_valid,
  input  logic                           i_pooling_ready,
  output logic [OUT_W*TIME_STEPS-1:0]    o_pooling_data,
  output logic                           o_frame_done
);

  localparam int T     = TIME_STEPS;
  localparam int RW    = IMG_WIDTH * TIME_STEPS;
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t           state, state_next;
  logic [15:0]      cfg_size;
  logic             cfg_mode;
  logic [15:0]      row_cnt;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    carry;
  logic [RW-1:0]    window;
  logic [IDX_W-1:0] scan_idx;
  logic             last_row;
  logic [T-1:0]     out_pix [OUT_W];
  logic [T-1:0]     win_pix [IMG_WIDTH];
  logic [T-1:0]     pix_val;
  logic             row_xfer;
  logic             odd_xfer;
  logic             scan_last;
  logic [IDX_W:0]   center_idx;

  // Odd rows close a window, so they must wait until the previous scan has been handed off.
  assign o_row_ready        = !s_rst && (!row_cnt[0] || state == IDLE);
  assign o_calculating_flag = (state != IDLE);
  assign row_xfer           = i_row_data_valid && o_row_ready && !code_valid;
  assign odd_xfer           = row_xfer && row_cnt[0];
  assign scan_last          = (16'(scan_idx) + 16'd1) == {1'b0, cfg_size[15:1]};
  assign center_idx         = {scan_idx, 1'b0};

  always_comb begin
    for (int i = 0; i < IMG_WIDTH; i++) win_pix[i] = window[i*T +: T];
  end

  always_comb begin
    pix_val = win_pix[center_idx] | win_pix[center_idx + 1'b1];
    if (cfg_mode && scan_idx != '0) pix_val = pix_val | win_pix[center_idx - 1'b1];
  end

  always_comb begin
    o_pooling_data = '0;
    for (int i = 0; i < OUT_W; i++) o_pooling_data[i*T +: T] = out_pix[i];
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (odd_xfer) state_next = SCAN;
      SCAN:    if (scan_last) state_next = HOLD;
      HOLD:    if (i_pooling_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (code_valid) state_next = IDLE;
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      cfg_size        <= '0;
      cfg_mode        <= 1'b0;
      row_cnt         <= '0;
      acc             <= '0;
      carry           <= '0;
      window          <= '0;
      scan_idx        <= '0;
      last_row        <= 1'b0;
      o_pooling_valid <= 1'b0;
      o_frame_done    <= 1'b0;
      for (int i = 0; i < OUT_W; i++) out_pix[i] <= '0;
    end else if (code_valid) begin
      cfg_size        <= conv_img_size;
      cfg_mode        <= pool_mode;
      row_cnt         <= '0;
      acc             <= '0;
      carry           <= '0;
      scan_idx        <= '0;
      o_pooling_valid <= 1'b0;
      o_frame_done    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;

      if (row_xfer) begin
        row_cnt <= (row_cnt == 16'(cfg_size - 16'd1)) ? '0 : row_cnt + 16'd1;
        if (!row_cnt[0]) begin
          // Row 0 is the top of the frame: the zero pad replaces the carried row.
          acc <= ((cfg_mode && row_cnt != '0) ? carry : '0) | i_row_data;
        end else begin
          window   <= acc | i_row_data;
          if (cfg_mode) carry <= i_row_data;
          scan_idx <= '0;
          last_row <= (row_cnt == 16'(cfg_size - 16'd1));
          for (int i = 0; i < OUT_W; i++) out_pix[i] <= '0;
        end
      end

      if (state == SCAN) begin
        out_pix[scan_idx] <= pix_val;
        scan_idx          <= scan_idx + 1'b1;
        if (scan_last) o_pooling_valid <= 1'b1;
      end

      if (state == HOLD && i_pooling_ready) begin
        o_pooling_valid <= 1'b0;
        if (last_row) begin
          carry        <= '0;
          o_frame_done <= 1'b1;
        end
      end
    end
  end

endmodule
